// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed latency, RISC-V lane select/extend.
// Optional macro DMEM_ERR_EN: flag illegal/misaligned accesses instead of force-aligning them.
module dmem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int         WORDS    = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    logic       access;

    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [31:0]           wdata_p0;
    logic                  write_p0;
    logic [2:0]            funct3_p0;

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            off;
    logic [2:0]            f3_eff;
    logic                  illegal;
    logic                  err;
    logic [31:0]           rd_word;
    logic [31:0]           st_data;
    logic [3:0]            st_be;

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;
    logic        err_q;

    // Lane select and sign/zero extension of a load result.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        sh = word >> {lane, 3'b000};
        b  = signed'(sh[7:0]);
        h  = signed'(sh[15:0]);
        case (f3)
            3'b000:  ext = 32'(b);
            3'b001:  ext = 32'(h);
            3'b100:  ext = signed'({24'h0, sh[7:0]});
            3'b101:  ext = signed'({16'h0, sh[15:0]});
            default: ext = signed'(word);
        endcase
        return unsigned'(ext);
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] w, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Request capture (stage p0): data only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_p0   <= req_addr_i[ADDR_WIDTH-1:0];
            wdata_p0  <= req_wdata_i;
            write_p0  <= req_write_i;
            funct3_p0 <= req_funct3_i;
        end
    end

    always_comb begin
        err     = 1'b0;
        off     = 2'b00;
        if (write_p0)
            illegal = !(funct3_p0 inside {3'b000, 3'b001, 3'b010});
        else
            illegal = funct3_p0 inside {3'b011, 3'b110, 3'b111};
        // Illegal codes degrade to a word access when errors are not reported.
        f3_eff = illegal ? 3'b010 : funct3_p0;
        case (f3_eff[1:0])
            2'b00: off = addr_p0[1:0];
            2'b01: begin
                off = {addr_p0[1], 1'b0};
`ifdef DMEM_ERR_EN
                err = addr_p0[0];
`endif
            end
            default: begin
                off = 2'b00;
`ifdef DMEM_ERR_EN
                err = |addr_p0[1:0];
`endif
            end
        endcase
`ifdef DMEM_ERR_EN
        err = err | illegal;
`endif
    end

    assign word_idx = addr_p0[ADDR_WIDTH-1:2];
    assign rd_word  = mem[word_idx];
    assign st_data  = store_lanes(wdata_p0, f3_eff);
    assign st_be    = store_mask(f3_eff, off);

    // Access stage: commit store or capture load result on the WAIT->RESP edge.
    always_ff @(posedge clk_i) begin
        if (access && write_p0 && !err) begin
            for (int k = 0; k < 4; k++) begin
                if (st_be[k])
                    mem[word_idx][8*k +: 8] <= st_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (access) begin
            rdata_q <= (write_p0 || err) ? 32'h0 : load_extend(rd_word, f3_eff, off);
            err_q   <= err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'h0) begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'h1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule
